// File: rtl/perf_mailbox.sv
// perf_mailbox
//
// Cycle-count mailbox that sits on the picoRV32 native memory bus, next to RAM.
// Firmware marks the end of each MNIST inference phase by writing SENTINEL to
// that phase's DONE register. The block counts the clock edges spent in each
// phase. The two counts, the saturation flags and the phase state can be read
// back over the same bus.
//
// Only accesses inside the 32-byte window at BASE_ADDR are claimed. Any other
// address is ignored and never acknowledged.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high (the core shares it)
//   mem_valid    bus request
//   mem_addr     byte address
//   mem_wdata    write data
//   mem_wstrb    byte strobes, 4'h0 = read
//   mem_ready    one-cycle acknowledge, one cycle after mem_valid
//   mem_rdata    read data, valid while mem_ready=1, otherwise 0
//   phase1_done  level, high in RUN2 and DONE
//   phase2_done  level, high in DONE
//   irq          (PERF_MAILBOX_IRQ_EN only) one-cycle pulse after each phase end
//
// Handshake: the request is seen while mem_valid=1 and the address is inside
// the window. The block raises mem_ready for exactly one cycle. The clock edge
// that raises mem_ready is the edge on which the transfer takes effect: write
// side effects happen there and read data is captured from pre-edge state.
// The master must drop mem_valid after seeing mem_ready. If mem_valid is still
// high on the next edge, mem_ready falls and a new transfer starts one edge
// later.
//
// Register map (word offset mem_addr[4:2])
//   0 CTRL    R: {25'b0, irq_enable, 1'b0, ovf2, ovf1, state[1:0], 1'b0}
//             W: wdata[0]=1 soft clear; wdata[6] irq_enable (IRQ build only)
//   1 DONE1   W: SENTINEL with all strobes ends phase 1; reads 0
//   2 DONE2   W: SENTINEL with all strobes ends phase 2; reads 0
//   3 COUNT1  R: zero-extended count1
//   4 COUNT2  R: zero-extended count2
//   5-7       read 0, writes acknowledged and ignored
//
// Optional feature macro: PERF_MAILBOX_IRQ_EN adds the irq output and the
// irq_enable bit (CTRL[6], reset 1).

module perf_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] SENTINEL  = 32'h7FFF_FFFF,
    parameter int          CW        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        phase1_done,
    output logic        phase2_done
`ifdef PERF_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        RUN1 = 2'd0,
        RUN2 = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [CW-1:0] count1_q, count1_d;
    logic [CW-1:0] count2_q, count2_d;
    logic          ovf1_q, ovf1_d;
    logic          ovf2_q, ovf2_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          sel;
    logic          ack;
    logic          is_write;
    logic          qualifying;
    logic          soft_clear;
    logic [2:0]    word;
    logic [31:0]   ctrl_rd;
    logic          irq_en_rd;

`ifdef PERF_MAILBOX_IRQ_EN
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
`endif

    // The byte lane bits are not decoded: all registers are word wide.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

    // Bus decode
    always_comb begin
        sel        = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
        // ack is high only on the edge that raises mem_ready, so a held
        // request is not applied twice.
        ack        = sel && !ready_q;
        word       = mem_addr[4:2];
        is_write   = (mem_wstrb != 4'h0);
        qualifying = (mem_wstrb == 4'hF) && (mem_wdata == SENTINEL);
        // CTRL bit 0 lives in byte lane 0, so that lane must be strobed.
        soft_clear = ack && (word == 3'd0) && mem_wstrb[0] && mem_wdata[0];
    end

    // Phase state machine, next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN1: if (ack && (word == 3'd1) && qualifying) state_d = RUN2;
            RUN2: if (ack && (word == 3'd2) && qualifying) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = RUN1;
        endcase
        if (soft_clear) begin
            state_d = RUN1;
        end
    end

    // Counters are updated from the pre-edge state. An increment past
    // all-ones is dropped and sets the sticky overflow flag instead.
    // A soft clear overrides the increment on the same edge.
    always_comb begin
        count1_d = count1_q;
        count2_d = count2_q;
        ovf1_d   = ovf1_q;
        ovf2_d   = ovf2_q;
        if (state_q == RUN1) begin
            if (count1_q == CNT_MAX) ovf1_d = 1'b1;
            else                     count1_d = count1_q + CNT_ONE;
        end
        if (state_q == RUN2) begin
            if (count2_q == CNT_MAX) ovf2_d = 1'b1;
            else                     count2_d = count2_q + CNT_ONE;
        end
        if (soft_clear) begin
            count1_d = '0;
            count2_d = '0;
            ovf1_d   = 1'b0;
            ovf2_d   = 1'b0;
        end
    end

`ifdef PERF_MAILBOX_IRQ_EN
    assign irq_en_rd = irq_en_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ack && (word == 3'd0) && mem_wstrb[0]) begin
            irq_en_d = mem_wdata[6];
        end
        irq_d = irq_en_q &&
                (((state_q == RUN1) && (state_d == RUN2)) ||
                 ((state_q == RUN2) && (state_d == DONE)));
    end
`else
    assign irq_en_rd = 1'b0;
`endif

    // Read data is captured on the ack edge and is zero at all other times.
    always_comb begin
        ctrl_rd = {25'b0, irq_en_rd, 1'b0, ovf2_q, ovf1_q, state_q, 1'b0};
        ready_d = ack;
        rdata_d = '0;
        if (ack && !is_write) begin
            case (word)
                3'd0:    rdata_d = ctrl_rd;
                3'd3:    rdata_d = 32'(count1_q);
                3'd4:    rdata_d = 32'(count2_q);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN1;
            count1_q <= '0;
            count2_q <= '0;
            ovf1_q   <= 1'b0;
            ovf2_q   <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            count1_q <= count1_d;
            count2_q <= count2_d;
            ovf1_q   <= ovf1_d;
            ovf2_q   <= ovf2_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef PERF_MAILBOX_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b1;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign phase1_done = (state_q == RUN2) || (state_q == DONE);
    assign phase2_done = (state_q == DONE);

endmodule

// File: tb/tb_perf_mailbox.sv
// Bench for perf_mailbox. Two instances share one bus. Instance 0 uses a
// 32-bit counter at 0x1000_0000. Instance 1 uses a 4-bit counter at
// 0x2000_0000 so that saturation can be reached.
// The reference model keeps the number of edges spent in each phase as an
// unbounded integer. The visible count is that number capped at all-ones, and
// overflow means the number went past all-ones.
// Valid/ready: the driver raises mem_valid on a falling edge and holds it until
// it sees mem_ready. It then drops mem_valid on the same falling edge, so each
// request is acknowledged once.
`timescale 1ns/1ps
module tb_perf_mailbox;
    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'h2000_0000;
    localparam logic [31:0] SENT  = 32'h7FFF_FFFF;

    // clock / reset
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        ready0, ready1;
    logic [31:0] rdata0, rdata1;
    logic        p1d0, p2d0, p1d1, p2d1;
`ifdef PERF_MAILBOX_IRQ_EN
    logic        irq0, irq1;
`endif

    always #5 clk = ~clk;

    perf_mailbox #(.BASE_ADDR(BASE0), .SENTINEL(SENT), .CW(32)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready0),
        .mem_rdata(rdata0), .phase1_done(p1d0), .phase2_done(p2d0)
`ifdef PERF_MAILBOX_IRQ_EN
        , .irq(irq0)
`endif
    );

    perf_mailbox #(.BASE_ADDR(BASE1), .SENTINEL(SENT), .CW(4)) dut1 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready1),
        .mem_rdata(rdata1), .phase1_done(p1d1), .phase2_done(p2d1)
`ifdef PERF_MAILBOX_IRQ_EN
        , .irq(irq1)
`endif
    );

    // reference model
    logic [31:0] bases[2] = '{BASE0, BASE1};
    longint      m_max[2] = '{longint'(32'hFFFF_FFFF), 15};
    int          m_state[2];
    longint      m_el1[2], m_el2[2];
    bit          m_ready[2];
    bit          m_irq_en[2];
    bit          m_irq[2];
    int          edge_cnt;
    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q0[$];   // {is_read, expected rdata}
    logic [32:0] exp_q1[$];

    function automatic longint sat(input longint el, input longint mx);
        return (el > mx) ? mx : el;
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [2:0] off);
        logic en_bit;
`ifdef PERF_MAILBOX_IRQ_EN
        en_bit = m_irq_en[i];
`else
        en_bit = 1'b0;
`endif
        case (off)
            3'd0: return {25'b0, en_bit, 1'b0, (m_el2[i] > m_max[i]),
                          (m_el1[i] > m_max[i]), 2'(m_state[i]), 1'b0};
            3'd3: return 32'(sat(m_el1[i], m_max[i]));
            3'd4: return 32'(sat(m_el2[i], m_max[i]));
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i]  = 0;
            m_el1[i]    = 0;
            m_el2[i]    = 0;
            m_ready[i]  = 0;
            m_irq_en[i] = 1;
            m_irq[i]    = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
        edge_cnt = 0;
    endtask

    // The model advances once per rising edge, from the pre-edge bus values.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            edge_cnt++;
            for (int i = 0; i < 2; i++) begin
                logic       sel, ack, qual;
                logic [2:0] off;
                logic [32:0] e;
                int         prev;
                sel  = mem_valid && (mem_addr[31:5] == bases[i][31:5]);
                ack  = sel && !m_ready[i];
                off  = mem_addr[4:2];
                qual = (mem_wstrb == 4'hF) && (mem_wdata == SENT);
                if (ack) begin
                    e = {(mem_wstrb == 4'h0), model_read(i, off)};
                    if (i == 0) exp_q0.push_back(e);
                    else        exp_q1.push_back(e);
                end
                prev = m_state[i];
                if (m_state[i] == 0)      m_el1[i]++;
                else if (m_state[i] == 1) m_el2[i]++;
                if (ack && off == 3'd0 && mem_wstrb[0]) begin
                    m_irq_en[i] = mem_wdata[6];
                    if (mem_wdata[0]) begin
                        m_el1[i] = 0;
                        m_el2[i] = 0;
                        m_state[i] = 0;
                    end
                end
                if (ack && off == 3'd1 && qual && m_state[i] == 0) m_state[i] = 1;
                if (ack && off == 3'd2 && qual && m_state[i] == 1) m_state[i] = 2;
                m_irq[i]   = (m_state[i] != prev) && (m_state[i] != 0) && (prev != 2) && m_irq_en[i];
                m_ready[i] = ack;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    initial forever begin
        logic [32:0] e;
        @(negedge clk);
        if (!reset) begin
            chk("ready0", ready0, m_ready[0]);
            chk("ready1", ready1, m_ready[1]);
            chk("phase1_done0", p1d0, m_state[0] >= 1);
            chk("phase2_done0", p2d0, m_state[0] == 2);
            chk("phase1_done1", p1d1, m_state[1] >= 1);
            chk("phase2_done1", p2d1, m_state[1] == 2);
`ifdef PERF_MAILBOX_IRQ_EN
            chk("irq0", irq0, m_irq[0]);
            chk("irq1", irq1, m_irq[1]);
`endif
            if (ready0) begin
                if (exp_q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack0: unexpected mem_ready, want none");
                end else begin
                    e = exp_q0.pop_front();
                    if (e[32]) chk("rdata0", rdata0, e[31:0]);
                end
            end
            if (ready1) begin
                if (exp_q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack1: unexpected mem_ready, want none");
                end else begin
                    e = exp_q1.pop_front();
                    if (e[32]) chk("rdata1", rdata1, e[31:0]);
                end
            end
        end
    end

    // driver tasks. They are called on a falling edge and return on a falling edge.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit expect_ack,
                        output logic [31:0] rd);
        bit got;
        got = 0;
        rd  = '0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (ready0 || ready1) begin
                got = 1;
                rd  = ready0 ? rdata0 : rdata1;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        total++;
        if (got != expect_ack) begin
            bad++;
            $display("FAIL ack @%h: got %0d want %0d", addr, got, expect_ack);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edge(input int n);
        for (int k = 0; k < 2000 && edge_cnt < n; k++) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd, a, b;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready0", ready0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_p1d0", p1d0, 0);
        chk("rst_p2d0", p2d0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_p1d1", p1d1, 0);
        reset = 1'b0;

        // Reset values read back, then the first phase ends on edge 50.
        xfer(BASE0 + 32'h0, 32'h0, 4'h0, 1, rd);
        chk("ctrl_after_reset", rd, 32'h0);
        wait_edge(49);
        chk("edge_before_done1", edge_cnt, 49);
        xfer(BASE0 + 32'h4, SENT, 4'hF, 1, rd);
        xfer(BASE0 + 32'hC, 32'h0, 4'h0, 1, rd);
        chk("count1_is_50", rd, 50);
        chk("phase1_done_set", p1d0, 1);

        // The second phase ends 30 edges later.
        wait_edge(79);
        xfer(BASE0 + 32'h8, SENT, 4'hF, 1, rd);
        xfer(BASE0 + 32'h10, 32'h0, 4'h0, 1, rd);
        chk("count2_is_30", rd, 30);
        chk("phase2_done_set", p2d0, 1);
        xfer(BASE0 + 32'h0, 32'h0, 4'h0, 1, rd);
        chk("ctrl_state_done", rd[2:1], 2);
        xfer(BASE0 + 32'h4, SENT, 4'hF, 1, rd);   // DONE1 in DONE: ignored
        idle(100);
        xfer(BASE0 + 32'hC, 32'h0, 4'h0, 1, rd);
        chk("count1_frozen", rd, 50);
        xfer(BASE0 + 32'h10, 32'h0, 4'h0, 1, rd);
        chk("count2_frozen", rd, 30);

        // Writes that must not end the phase: wrong value, partial strobes.
        xfer(BASE0 + 32'h0, 32'h1, 4'hF, 1, rd);
        xfer(BASE0 + 32'h4, 32'h7FFF_FFFE, 4'hF, 1, rd);
        xfer(BASE0 + 32'h4, SENT, 4'h3, 1, rd);
        xfer(BASE0 + 32'h8, SENT, 4'hF, 1, rd);   // DONE2 in RUN1: ignored
        xfer(BASE0 + 32'h0, 32'h0, 4'h0, 1, rd);
        chk("state_stays_run1", rd[2:1], 0);
        xfer(BASE0 + 32'hC, 32'h0, 4'h0, 1, a);
        idle(5);
        xfer(BASE0 + 32'hC, 32'h0, 4'h0, 1, b);
        chk("count1_keeps_counting", b > a, 1);

        // A 4-bit counter saturates and raises ovf1, and soft clear resets both.
        xfer(BASE1 + 32'hC, 32'h0, 4'h0, 1, rd);
        chk("count1_saturated", rd, 15);
        xfer(BASE1 + 32'h0, 32'h0, 4'h0, 1, rd);
        chk("ovf1_set", rd[3], 1);
        xfer(BASE1 + 32'h0, 32'h1, 4'hF, 1, rd);
        xfer(BASE1 + 32'h0, 32'h0, 4'h0, 1, rd);
        chk("ovf1_cleared", rd[3], 0);
        chk("state_cleared", rd[2:1], 0);
        xfer(BASE1 + 32'hC, 32'h0, 4'h0, 1, rd);
        chk("count1_restarted", rd < 4, 1);

        // Window decode: outside the window, unused offset, write-only register.
        xfer(BASE0 + 32'h100, 32'h0, 4'h0, 0, rd);
        xfer(BASE0 + 32'h1C, 32'h0, 4'h0, 1, rd);
        chk("offset_1c_reads_0", rd, 0);
        xfer(BASE0 + 32'h4, 32'h0, 4'h0, 1, rd);
        chk("done1_reads_0", rd, 0);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [31:0] base, wd;
            logic [3:0]  st;
            base = ($urandom_range(0, 1) == 0) ? BASE0 : BASE1;
            case ($urandom_range(0, 3))
                0:       st = 4'h0;
                1, 2:    st = 4'hF;
                default: st = 4'h3;
            endcase
            wd = ($urandom_range(0, 1) == 0) ? SENT : $urandom();
            xfer(base + {27'b0, 3'($urandom_range(0, 7)), 2'b00}, wd, st, 1, rd);
            idle($urandom_range(0, 3));
        end

        // Reset arrives while a DONE2 write is being acknowledged.
        xfer(BASE0 + 32'h0, 32'h1, 4'hF, 1, rd);
        xfer(BASE0 + 32'h4, SENT, 4'hF, 1, rd);
        chk("in_run2", p1d0, 1);
        mem_valid = 1'b1;
        mem_addr  = BASE0 + 32'h8;
        mem_wdata = SENT;
        mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        model_reset();
        #1;
        chk("midreset_ready", ready0, 0);
        chk("midreset_rdata", rdata0, 0);
        chk("midreset_p1d", p1d0, 0);
        chk("midreset_p2d", p2d0, 0);
        idle(2);
        reset = 1'b0;
        xfer(BASE0 + 32'h0, 32'h0, 4'h0, 1, rd);
        chk("after_reset_ctrl", rd, 0);

        idle(3);
        total++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL pending: got %0d/%0d outstanding want 0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global timeout
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
